// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator motion controller.
package elevator_pkg;

    localparam int NUM_FLOORS = 7;
    localparam int FLOOR_W    = 3;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        ARRIVE,
        DOOR_OPEN
    } motion_state_t;

    localparam floor_t TOP_FLOOR = floor_t'(NUM_FLOORS - 1);

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t f);
        logic [NUM_FLOORS-1:0] one;
        one = 1;
        return one << f;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable 8-bit down-counter; load wins over enable and the count holds at zero.
module elevator_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && count_q != 8'd0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == 8'd0);

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion FSM: travels one floor at a time, opens the door at requested
// floors and refuses moves that would leave the shaft.
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] queue_status,
    input  logic                  next_up_ndown,
    input  logic                  queue_empty,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  current_up_ndown,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] clear_req,
    output logic                  bound_err
);

    motion_state_t         state_q, state_d;
    floor_t                floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic                  moving_q, moving_d;
    logic                  door_q, door_d;
    logic [NUM_FLOORS-1:0] clr_q, clr_d;
    logic                  berr_q, berr_d;

    logic travel_load, travel_zero;
    logic door_load, door_zero;
    logic req_here, rereq, blocked;

    assign req_here = queue_status[floor_q];
    // The queue only drops the bit at the end of the pulse cycle, so a request
    // seen while its own clear is in flight is not a new request.
    assign rereq    = req_here && !clr_q[floor_q];
    assign blocked  = next_up_ndown ? (floor_q == TOP_FLOOR) : (floor_q == floor_t'(0));

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_d       = dir_q;
        clr_d       = '0;
        berr_d      = berr_q;
        travel_load = 1'b0;
        door_load   = 1'b0;
        case (state_q)
            IDLE, ARRIVE: begin
                if (req_here) begin
                    state_d   = DOOR_OPEN;
                    door_load = 1'b1;
                    clr_d     = floor_onehot(floor_q);
                end else if (!queue_empty) begin
                    if (blocked) begin
                        berr_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dir_d       = next_up_ndown;
                        state_d     = MOVE;
                        travel_load = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (travel_zero) begin
                    floor_d = dir_q ? floor_q + floor_t'(1) : floor_q - floor_t'(1);
                    state_d = ARRIVE;
                end
            end
            DOOR_OPEN: begin
                if (door_hold || rereq) begin
                    door_load = 1'b1;
                    if (rereq)
                        clr_d = floor_onehot(floor_q);
                end else if (door_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        moving_d = (state_d == MOVE);
        door_d   = (state_d == DOOR_OPEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
            clr_q    <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            door_q   <= door_d;
            clr_q    <= clr_d;
            berr_q   <= berr_d;
        end
    end

    elevator_timer u_travel_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (travel_load),
        .en       (state_q == MOVE),
        .load_val (8'(TRAVEL_CYCLES - 1)),
        .zero     (travel_zero)
    );

    elevator_timer u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (door_load),
        .en       (state_q == DOOR_OPEN),
        .load_val (8'(DOOR_CYCLES - 1)),
        .zero     (door_zero)
    );

    assign current_floor    = floor_q;
    assign current_up_ndown = dir_q;
    assign moving           = moving_q;
    assign door_open        = door_q;
    assign clear_req        = clr_q;
    assign bound_err        = berr_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench: stimulus queues expected events; a negedge monitor pops and compares them.
module tb_elevator_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] queue_status;
    logic       next_up_ndown;
    logic       queue_empty;
    logic       door_hold = 1'b0;
    logic [2:0] current_floor;
    logic       current_up_ndown;
    logic       moving;
    logic       door_open;
    logic [6:0] clear_req;
    logic       bound_err;

    logic [6:0] reqs;
    logic [6:0] add_req = 7'd0;
    logic       flush = 1'b1;
    logic       force_on = 1'b0;
    logic       mon_en = 1'b0;
    logic       resolve_up;

    typedef enum int {EV_MOVE, EV_CLR, EV_DOOR, EV_BERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  mv_len = 0;
    int  dr_len = 0;
    logic berr_prev = 1'b0;

    always #5 clk = ~clk;

    elevator_motion_ctrl #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .queue_status     (queue_status),
        .next_up_ndown    (next_up_ndown),
        .queue_empty      (queue_empty),
        .door_hold        (door_hold),
        .current_floor    (current_floor),
        .current_up_ndown (current_up_ndown),
        .moving           (moving),
        .door_open        (door_open),
        .clear_req        (clear_req),
        .bound_err        (bound_err)
    );

    // Request queue model: set by the bench, cleared by the DUT pulse.
    always @(posedge clk) begin
        if (flush) reqs <= 7'd0;
        else       reqs <= (reqs | add_req) & ~clear_req;
    end

    always_comb begin
        logic up_any, dn_any;
        up_any = 1'b0;
        dn_any = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (reqs[i] && i > int'(current_floor)) up_any = 1'b1;
            if (reqs[i] && i < int'(current_floor)) dn_any = 1'b1;
        end
        resolve_up = up_any ? 1'b1 : (dn_any ? 1'b0 : current_up_ndown);
    end

    assign queue_status  = reqs;
    assign queue_empty   = force_on ? 1'b0 : (reqs == 7'd0);
    assign next_up_ndown = force_on ? 1'b1 : resolve_up;

    function automatic string kname(ev_kind_t k);
        case (k)
            EV_MOVE: return "move_len";
            EV_CLR:  return "clear_req";
            EV_DOOR: return "door_len";
            default: return "bound_err_floor";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_kind_t k, input int v);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected %s event: got %0d, expected none", kname(k), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                miscompares++;
                $display("FAIL event: got %s=%0d, expected %s=%0d",
                         kname(k), v, kname(e.kind), e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if ((moving && door_open) || current_floor > 3'd6) begin
                miscompares++;
                $display("FAIL invariant: moving=%0b door_open=%0b floor=%0d, expected exclusive and floor<=6",
                         moving, door_open, current_floor);
            end
            if (clear_req != 7'd0) got(EV_CLR, int'(clear_req));
            if (moving) mv_len++;
            else if (mv_len != 0) begin
                got(EV_MOVE, mv_len);
                mv_len = 0;
            end
            if (door_open) dr_len++;
            else if (dr_len != 0) begin
                got(EV_DOOR, dr_len);
                dr_len = 0;
            end
            if (bound_err && !berr_prev) got(EV_BERR, int'(current_floor));
            berr_prev = bound_err;
        end
    end

    task automatic post_req(input int n);
        add_req = 7'd1 << n;
        @(negedge clk);
        add_req = 7'd0;
    endtask

    task automatic drain(input int budget, input string what);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got %0d outstanding events, expected 0", what, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_door(input int budget, input string what);
        int n = 0;
        while (!door_open && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!door_open) check({what, " door wait timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        mon_en = 1'b1;
        check("rst floor", current_floor, 0);
        check("rst dir", current_up_ndown, 1);
        check("rst moving", moving, 0);
        check("rst door", door_open, 0);
        check("rst clear", clear_req, 0);
        check("rst bound_err", bound_err, 0);

        repeat (20) @(negedge clk);
        check("idle floor", current_floor, 0);
        check("idle moving", moving, 0);
        check("idle door", door_open, 0);
        check("idle clear", clear_req, 0);

        // Single trip 0 -> 3
        repeat (3) expect_ev(EV_MOVE, 8);
        expect_ev(EV_CLR, 8);
        expect_ev(EV_DOOR, 4);
        post_req(3);
        drain(200, "trip");
        check("trip floor", current_floor, 3);
        check("trip dir", current_up_ndown, 1);

        // Door hold sampled on 5 edges starting with the first door cycle
        expect_ev(EV_CLR, 8);
        expect_ev(EV_DOOR, 9);
        post_req(3);
        wait_door(50, "hold");
        door_hold = 1'b1;
        repeat (5) @(negedge clk);
        door_hold = 1'b0;
        drain(100, "hold");
        check("hold floor", current_floor, 3);

        do_reset();
        check("reset2 floor", current_floor, 0);

        // Pass-through 0 -> 5
        repeat (5) expect_ev(EV_MOVE, 8);
        expect_ev(EV_CLR, 32);
        expect_ev(EV_DOOR, 4);
        post_req(5);
        drain(300, "pass");
        check("pass floor", current_floor, 5);

        // Same-floor request during dwell re-pulses and restarts dwell
        expect_ev(EV_CLR, 32);
        expect_ev(EV_CLR, 32);
        expect_ev(EV_DOOR, 7);
        post_req(5);
        wait_door(50, "repulse");
        @(negedge clk);
        post_req(5);
        drain(100, "repulse");

        expect_ev(EV_MOVE, 8);
        expect_ev(EV_CLR, 64);
        expect_ev(EV_DOOR, 4);
        post_req(6);
        drain(100, "to6");
        check("top floor", current_floor, 6);

        // Upward move refused at the top floor
        expect_ev(EV_BERR, 6);
        force_on = 1'b1;
        repeat (10) @(negedge clk);
        check("bound moving", moving, 0);
        check("bound floor", current_floor, 6);
        check("bound flag", bound_err, 1);
        check("bound dir", current_up_ndown, 1);
        force_on = 1'b0;
        drain(5, "bound");

        // Downward trip 6 -> 4
        repeat (2) expect_ev(EV_MOVE, 8);
        expect_ev(EV_CLR, 16);
        expect_ev(EV_DOOR, 4);
        post_req(4);
        drain(100, "down");
        check("down floor", current_floor, 4);
        check("down dir", current_up_ndown, 0);
        check("sticky bound_err", bound_err, 1);

        do_reset();
        check("reset3 bound_err", bound_err, 0);
        check("reset3 dir", current_up_ndown, 1);

        // Reset on cycle 5 of the 2 -> 3 move
        repeat (2) expect_ev(EV_MOVE, 8);
        expect_ev(EV_MOVE, 5);
        post_req(3);
        n = 0;
        while (!(moving && current_floor == 3'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach 2->3 move", int'(moving && current_floor == 3'd2), 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        check("midrst floor", current_floor, 0);
        check("midrst moving", moving, 0);
        check("midrst door", door_open, 0);
        check("midrst clear", clear_req, 0);
        drain(5, "midrst");
        repeat (10) @(negedge clk);
        check("post-rst idle", moving, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/elevator_motion_ctrl.md
ELEVATOR_MOTION_CTRL -- requirements
Module: elevator_motion_ctrl

Interface
REQ-001 Parameter TRAVEL_CYCLES, 8: clock cycles to travel one floor; legal range 2..255.
REQ-002 Parameter DOOR_CYCLES, 4: clock cycles the door stays open; legal range 2..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 queue_status  input  7  pending floor requests, bit n = floor n.
REQ-006 next_up_ndown  input  1  direction from the direction resolver (1 = up).
REQ-007 queue_empty  input  1  resolver flag: no pending requests.
REQ-008 door_hold  input  1  door-reopen button, level-sensitive.
REQ-009 current_floor  output  3  registered car position, 0..6; feeds the resolver.
REQ-010 current_up_ndown  output  1  registered travel direction; feeds the resolver.
REQ-011 moving  output  1  high while in state MOVE.
REQ-012 door_open  output  1  high while in state DOOR_OPEN.
REQ-013 clear_req  output  7  one-hot, one-cycle pulse that clears the serviced floor in the request queue.
REQ-014 bound_err  output  1  sticky flag: an out-of-range move was refused.

Function
REQ-015 The FSM SHALL have the states IDLE, MOVE, ARRIVE and DOOR_OPEN; all outputs are registered.
REQ-016 IDLE SHALL follow this priority:
- queue_status[current_floor]=1 -> DOOR_OPEN;
- else queue_empty=0 -> latch current_up_ndown <= next_up_ndown and go to MOVE;
- else stay in IDLE.
REQ-017 On entry to MOVE, the travel counter SHALL load TRAVEL_CYCLES-1 and decrement once per cycle.
REQ-018 At count 0 in MOVE, the block SHALL update current_floor by +1 (up) or -1 (down) and enter ARRIVE; travel time is exactly TRAVEL_CYCLES cycles in MOVE per floor.
REQ-019 ARRIVE lasts one cycle, using the updated current_floor, and SHALL follow this priority:
- request at current_floor -> DOOR_OPEN;
- else queue_empty -> IDLE;
- else latch next_up_ndown and go to MOVE.
REQ-020 Before entering MOVE from IDLE or ARRIVE, the block SHALL refuse the move and set bound_err if the direction is up at floor 6 or down at floor 0. In that case it goes to IDLE and current_floor is unchanged.
REQ-021 On entry to DOOR_OPEN, clear_req SHALL pulse 1<<current_floor for exactly the first DOOR_OPEN cycle, and the dwell counter SHALL load DOOR_CYCLES-1.
REQ-022 DOOR_OPEN SHALL last DOOR_CYCLES cycles, then go to IDLE.
REQ-023 During DOOR_OPEN, either of these SHALL reload the dwell counter to DOOR_CYCLES-1:
- door_hold=1;
- queue_status[current_floor]=1; this case also re-pulses clear_req for one cycle.
REQ-024 current_up_ndown SHALL change only on a transition into MOVE.
REQ-025 clear_req SHALL be all-zero outside the pulses defined in REQ-021 and REQ-023.
REQ-026 moving and door_open SHALL never be high together.
REQ-027 current_floor SHALL never leave the range 0..6.
REQ-028 Requests arriving mid-MOVE SHALL be evaluated only in ARRIVE. Travel to the next floor is never aborted.

Reset
REQ-029 On rst=1 at a clock edge, the block SHALL set: state=IDLE, current_floor=0, current_up_ndown=1, moving=0, door_open=0, clear_req=0, bound_err=0, both counters=0.
REQ-030 Reset mid-MOVE or mid-DOOR_OPEN SHALL abandon the operation immediately and emit no clear_req pulse.
REQ-031 rst SHALL take priority over every other input.

Structure
REQ-032 Package elevator_pkg SHALL hold:
- NUM_FLOORS=7;
- FLOOR_W=3;
- the typedef floor_t;
- the enum motion_state_t {IDLE, MOVE, ARRIVE, DOOR_OPEN}.
REQ-033 A sub-module elevator_timer (loadable 8-bit down-counter with load, enable and zero flag) SHALL be instantiated twice: once for travel and once for door dwell.

Verification (TRAVEL_CYCLES=8, DOOR_CYCLES=4)
REQ-034 Reset then idle: queue_status=0, queue_empty=1 for 20 cycles -> current_floor=0, moving=0, door_open=0, clear_req=0.
REQ-035 Single trip: at floor 0 drive queue_status=7'b0001000, next_up_ndown=1, queue_empty=0 -> 3 floors x (8 MOVE + 1 ARRIVE) cycles, then door_open for 4 cycles; clear_req=7'b0001000 for one cycle; current_floor=3.
REQ-036 Door hold: at floor 3 in DOOR_OPEN, assert door_hold for 5 cycles -> door_open stays high for 5+4 cycles total after release timing; then IDLE.
REQ-037 Pass-through: traveling up from floor 0 with request at floor 5 only -> no door_open at floors 1-4; ARRIVE goes straight to MOVE each time.
REQ-038 Bounds: at floor 6, force next_up_ndown=1, queue_empty=0, request bit 6 clear -> no MOVE, bound_err=1, current_floor=6.
REQ-039 Reset mid-travel: assert rst at cycle 5 of MOVE 2->3 -> next cycle current_floor=0, state IDLE, clear_req=0.
